result_drain_stage: RTL and testbench

Parametrised, handshaked successor to the per-row result select register in the result path of the sparse CNN accelerator.

- Each stage captures its PE row's local results on a capture pulse and emits them as one beat.
- It then forwards all upstream beats until it passes the upstream last beat.
- It supports any lane count and word width, valid/ready back-pressure, head-of-chain mode, beat counting and capture-overflow detection.

---
 rtl/result_chain_pkg.sv | 9 +
 rtl/result_drain_stage_if.sv | 21 ++
 rtl/result_out_reg.sv | 32 +++
 rtl/result_drain_stage.sv | 106 ++++++++++
 tb/tb_result_drain_stage.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_chain_pkg.sv
// Shared definitions for the result drain chain: FSM encoding and the
// default beat geometry also used by the PE array.
package result_chain_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES_DEF      = 4;
  localparam int PACK_DEF       = 4;

  typedef enum logic [1:0] {IDLE, EMIT, FORWARD} drain_state_t;
endpackage

// File: rtl/result_drain_stage_if.sv
// Upstream/downstream beat handshake of one drain stage.
// slave = stage side, master = neighbour/environment side.
interface result_drain_stage_if #(parameter int W = 128);
  logic         up_valid;
  logic [W-1:0] up_data;
  logic         up_last;
  logic         up_ready;
  logic         dn_valid;
  logic [W-1:0] dn_data;
  logic         dn_last;
  logic         dn_ready;

  modport slave (
    input  up_valid, up_data, up_last, dn_ready,
    output up_ready, dn_valid, dn_data, dn_last
  );
  modport master (
    output up_valid, up_data, up_last, dn_ready,
    input  up_ready, dn_valid, dn_data, dn_last
  );
endinterface

// File: rtl/result_out_reg.sv
// Single-entry valid/ready register carrying a data word and a last flag.
// Accepts a new beat whenever it is empty or being drained this cycle.
module result_out_reg #(
  parameter int W = 128
)(
  input  logic         Clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/result_drain_stage.sv
// One stage of the result drain chain: emits the captured local PE-row beat,
// then passes upstream beats through until the upstream last beat.
module result_drain_stage
  import result_chain_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int PACK       = PACK_DEF,
  parameter int CNT_W      = 8
)(
  input  logic                               Clk,
  input  logic                               rst,
  input  logic                               capture,
  input  logic                               cfg_head,
  input  logic [LANES*PACK*DATA_WIDTH-1:0]   local_data,
  result_drain_stage_if.slave                bus,
  output logic                               busy,
  output logic                               overflow,
  output logic                               drained,
  output logic [CNT_W-1:0]                   beat_cnt
);
  localparam int WORD_W = PACK * DATA_WIDTH;
  localparam int W      = LANES * WORD_W;

  drain_state_t                   state_q, state_d;
  logic [LANES-1:0][WORD_W-1:0]   local_q;
  logic                           head_q;
  logic                           dn_free;
  logic                           cap_acc, load_emit, load_fwd, up_rdy;
  logic                           ld_valid, ld_last;
  logic [W-1:0]                   ld_data;
  logic                           dn_hs;

  // State register
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture) state_d = EMIT;
      EMIT:    if (dn_free) state_d = head_q ? IDLE : FORWARD;
      FORWARD: if (load_fwd && bus.up_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode; up_ready never looks at up_valid
  always_comb begin
    cap_acc   = 1'b0;
    load_emit = 1'b0;
    up_rdy    = 1'b0;
    unique case (state_q)
      IDLE:    cap_acc   = capture;
      EMIT:    load_emit = dn_free;
      FORWARD: up_rdy    = dn_free;
      default: ;
    endcase
  end

  assign load_fwd     = up_rdy && bus.up_valid;
  assign bus.up_ready = up_rdy;

  assign ld_valid = load_emit || load_fwd;
  assign ld_data  = load_emit ? W'(local_q) : bus.up_data;
  assign ld_last  = load_emit ? head_q      : bus.up_last;

  result_out_reg #(.W(W)) u_out (
    .Clk       (Clk),
    .rst       (rst),
    .in_valid  (ld_valid),
    .in_data   (ld_data),
    .in_last   (ld_last),
    .in_ready  (dn_free),
    .out_valid (bus.dn_valid),
    .out_data  (bus.dn_data),
    .out_last  (bus.dn_last),
    .out_ready (bus.dn_ready)
  );

  assign dn_hs = bus.dn_valid && bus.dn_ready;
  assign busy  = (state_q != IDLE) || bus.dn_valid;

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      local_q  <= '0;
      head_q   <= 1'b0;
      overflow <= 1'b0;
      drained  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      drained <= dn_hs && bus.dn_last;
      if (cap_acc) begin
        local_q <= local_data;
        head_q  <= cfg_head;
      end
      if (capture && state_q != IDLE) overflow <= 1'b1;
      // The count restarts on a new capture even if an older beat retires now
      if (cap_acc)                  beat_cnt <= '0;
      else if (dn_hs && !(&beat_cnt)) beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_result_drain_stage.sv
// Directed bench for result_drain_stage: expected-beat queue model checked
// every cycle, plus literal expectations per scenario.
module tb_result_drain_stage;
  localparam int W = 128;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  logic         Clk = 1'b0;
  logic         rst;
  logic         capture, cfg_head;
  logic [W-1:0] local_data;
  logic         busy, overflow, drained;
  logic [7:0]   beat_cnt;

  result_drain_stage_if #(.W(W)) bus ();

  result_drain_stage #(.DATA_WIDTH(8), .LANES(4), .PACK(4), .CNT_W(8)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .capture    (capture),
    .cfg_head   (cfg_head),
    .local_data (local_data),
    .bus        (bus),
    .busy       (busy),
    .overflow   (overflow),
    .drained    (drained),
    .beat_cnt   (beat_cnt)
  );

  always #5 Clk = ~Clk;

  int           checks = 0;
  int           failures = 0;
  beat_t        exp_q[$];
  logic [W-1:0] log_q[$];
  logic [7:0]   cnt_exp = '0;
  logic         ovf_exp = 1'b0;
  logic         drn_exp = 1'b0;
  logic         cap_acc = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  // Model: sampled at negedge when inputs and registered outputs are stable
  always @(negedge Clk) begin
    if (rst) begin
      exp_q.delete();
      cnt_exp = '0;
      ovf_exp = 1'b0;
      drn_exp = 1'b0;
    end else begin
      chk("drained", drained, drn_exp);
      chk("beat_cnt", beat_cnt, cnt_exp);
      chk("overflow", overflow, ovf_exp);
      if (bus.dn_valid) begin
        if (exp_q.size() == 0) fail_now("dn_spurious_beat");
        else begin
          chk("dn_data", bus.dn_data, exp_q[0].d);
          chk("dn_last", bus.dn_last, exp_q[0].l);
        end
        if (!bus.dn_ready) chk("up_ready_backpressure", bus.up_ready, 0);
      end
      drn_exp = bus.dn_valid && bus.dn_ready && bus.dn_last;
      if (bus.dn_valid && bus.dn_ready) begin
        log_q.push_back(bus.dn_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (cnt_exp != 8'hFF) cnt_exp = cnt_exp + 8'd1;
      end
      if (capture) begin
        if (cap_acc) begin
          exp_q.push_back('{d: local_data, l: cfg_head});
          cnt_exp = '0;
        end else ovf_exp = 1'b1;
      end
      if (bus.up_valid && bus.up_ready) exp_q.push_back('{d: bus.up_data, l: bus.up_last});
    end
  end

  task automatic do_capture(input logic [W-1:0] d, input logic h, input logic acc);
    local_data = d;
    cfg_head   = h;
    cap_acc    = acc;
    capture    = 1'b1;
    @(posedge Clk); #1;
    capture    = 1'b0;
  endtask

  task automatic send_up(input int n, input logic [7:0] b0);
    logic [7:0] b;
    int t;
    b = b0;
    for (int i = 0; i < n; i++) begin
      bus.up_valid = 1'b1;
      bus.up_data  = {16{b}};
      bus.up_last  = (i == n - 1);
      t = 0;
      do begin @(negedge Clk); t++; end while (!bus.up_ready && t < 100);
      if (!bus.up_ready) fail_now("up_ready_wait");
      @(posedge Clk); #1;
      b = b + 8'd1;
    end
    bus.up_valid = 1'b0;
    bus.up_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge Clk); t++; end while ((busy || exp_q.size() != 0) && t < 200);
    if (busy) fail_now("drain_complete");
    @(posedge Clk); #1;
  endtask

  localparam logic [W-1:0] L1 = 128'h3F3E3D3C_2F2E2D2C_1F1E1D1C_0D0C0B0A;
  localparam logic [W-1:0] L2 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  localparam logic [W-1:0] L3 = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  localparam logic [W-1:0] L4 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
  localparam logic [W-1:0] LX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [W-1:0] L5 = 128'h50505050_51515151_52525252_53535353;
  localparam logic [W-1:0] L6 = 128'h60606060_61616161_62626262_63636363;
  localparam logic [W-1:0] L7 = 128'h70707070_71717171_72727272_73737373;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; capture = 1'b0; cfg_head = 1'b0; local_data = '0;
    bus.up_valid = 1'b0; bus.up_data = '0; bus.up_last = 1'b0; bus.dn_ready = 1'b1;
    #2;
    chk("rst_dn_valid", bus.dn_valid, 0);
    chk("rst_dn_data", bus.dn_data, 0);
    chk("rst_dn_last", bus.dn_last, 0);
    chk("rst_up_ready", bus.up_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drained", drained, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    @(posedge Clk); #1; rst = 1'b0;
    @(posedge Clk); #1;

    // 1: head mode, two-cycle latency
    log_q.delete();
    do_capture(L1, 1'b1, 1'b1);
    chk("t1_up_ready_idle", bus.up_ready, 0);
    @(posedge Clk); #1;
    chk("t1_dn_valid", bus.dn_valid, 1);
    chk("t1_dn_data", bus.dn_data, L1);
    chk("t1_dn_last", bus.dn_last, 1);
    @(posedge Clk); #1;
    chk("t1_drained", drained, 1);
    chk("t1_beat_cnt", beat_cnt, 1);
    chk("t1_dn_valid_after", bus.dn_valid, 0);
    wait_idle();

    // 2: chain mode, three back-to-back upstream beats
    log_q.delete();
    do_capture(L2, 1'b0, 1'b1);
    send_up(3, 8'h11);
    bus.up_data = '0;
    wait_idle();
    chk("t2_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t2_beat0", log_q[0], L2);
      chk("t2_beat1", log_q[1], {16{8'h11}});
      chk("t2_beat2", log_q[2], {16{8'h12}});
      chk("t2_beat3", log_q[3], {16{8'h13}});
    end
    chk("t2_beat_cnt", beat_cnt, 4);
    chk("t2_busy", busy, 0);

    // 3: five-cycle downstream stall mid-forward
    log_q.delete();
    do_capture(L3, 1'b0, 1'b1);
    fork
      send_up(4, 8'h51);
      begin
        repeat (2) begin @(posedge Clk); #1; end
        bus.dn_ready = 1'b0;
        @(negedge Clk);
        held = bus.dn_data;
        chk("t3_stall_valid", bus.dn_valid, 1);
        repeat (5) begin
          chk("t3_up_ready", bus.up_ready, 0);
          chk("t3_hold", bus.dn_data, held);
          @(negedge Clk);
        end
        @(posedge Clk); #1;
        bus.dn_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t3_count", log_q.size(), 5);
    if (log_q.size() == 5) begin
      chk("t3_beat0", log_q[0], L3);
      chk("t3_beat1", log_q[1], {16{8'h51}});
      chk("t3_beat4", log_q[4], {16{8'h54}});
    end
    chk("t3_beat_cnt", beat_cnt, 5);

    // 4: capture during FORWARD is dropped and flagged
    log_q.delete();
    do_capture(L4, 1'b0, 1'b1);
    fork
      send_up(3, 8'h41);
      begin
        repeat (2) begin @(posedge Clk); #1; end
        do_capture(LX, 1'b1, 1'b0);
      end
    join
    wait_idle();
    chk("t4_overflow", overflow, 1);
    chk("t4_count", log_q.size(), 4);
    if (log_q.size() == 4) chk("t4_beat0", log_q[0], L4);
    repeat (3) begin @(posedge Clk); #1; end
    chk("t4_overflow_sticky", overflow, 1);

    // 5: asynchronous reset while a beat is held
    bus.dn_ready = 1'b0;
    do_capture(L5, 1'b0, 1'b1);
    @(posedge Clk); #1;
    chk("t5_pre_valid", bus.dn_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_dn_valid", bus.dn_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_beat_cnt", beat_cnt, 0);
    chk("t5_overflow", overflow, 0);
    @(posedge Clk); #1; rst = 1'b0; bus.dn_ready = 1'b1;
    @(posedge Clk); #1;
    log_q.delete();
    do_capture(L1, 1'b1, 1'b1);
    wait_idle();
    chk("t5_after_count", log_q.size(), 1);
    if (log_q.size() == 1) chk("t5_after_data", log_q[0], L1);
    chk("t5_after_beat_cnt", beat_cnt, 1);

    // 6: new capture accepted while previous last beat is stalled
    log_q.delete();
    do_capture(L6, 1'b0, 1'b1);
    send_up(2, 8'h61);
    bus.dn_ready = 1'b0;
    do_capture(L7, 1'b1, 1'b1);
    @(posedge Clk); #1;
    chk("t6_stalled_data", bus.dn_data, {16{8'h62}});
    chk("t6_stalled_last", bus.dn_last, 1);
    @(posedge Clk); #1;
    bus.dn_ready = 1'b1;
    wait_idle();
    chk("t6_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t6_beat2", log_q[2], {16{8'h62}});
      chk("t6_beat3", log_q[3], L7);
    end
    chk("t6_overflow", overflow, 0);
    chk("t6_beat_cnt", beat_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
